// File: rtl/mips_pkg.sv
// Shared constants and helpers for the datapath multiplexers.
package mips_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   // Index width for n channels, never narrower than one bit.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/arb_mux_nx1_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant wins, with wrap.
module rr_arbiter
   import mips_pkg::*;
#(
   parameter  int NUM_INPUTS = 4,
   localparam int SEL_WIDTH  = clog2(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0] i_req,
   input  logic [SEL_WIDTH-1:0]  i_last_grant,
   output logic [NUM_INPUTS-1:0] o_gnt,
   output logic [SEL_WIDTH-1:0]  o_gnt_idx,
   output logic                  o_gnt_vld
);

   always_comb begin
      logic [SEL_WIDTH-1:0] w_cand;
      o_gnt     = '0;
      o_gnt_idx = '0;
      o_gnt_vld = 1'b0;
      w_cand    = '0;
      // Offset NUM_INPUTS brings the search back to last_grant itself, checked last.
      for (int k = 1; k <= NUM_INPUTS; k++) begin
         w_cand = SEL_WIDTH'((int'(i_last_grant) + k) % NUM_INPUTS);
         if (!o_gnt_vld && i_req[w_cand]) begin
            o_gnt_vld     = 1'b1;
            o_gnt[w_cand] = 1'b1;
            o_gnt_idx     = w_cand;
         end
      end
   end

endmodule

// File: rtl/arb_mux_nx1.sv
// Registered N-to-1 mux with valid/ready on every channel; direct select or round-robin.
module arb_mux_nx1
   import mips_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int NUM_INPUTS = 4,
   localparam int SEL_WIDTH  = clog2(NUM_INPUTS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             mode,
   input  logic [SEL_WIDTH-1:0]             sel,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_INPUTS-1:0]            in_valid,
   output logic [NUM_INPUTS-1:0]            in_ready,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [SEL_WIDTH-1:0]             out_src
);

   logic [DATA_WIDTH-1:0] r_data_p1;
   logic [SEL_WIDTH-1:0]  r_src_p1;
   logic                  r_vld_p1;
   logic [SEL_WIDTH-1:0]  r_last_grant;

   logic                  w_can_accept;
   logic [NUM_INPUTS-1:0] w_rr_gnt;
   logic [SEL_WIDTH-1:0]  w_rr_idx;
   logic                  w_rr_vld;
   logic [NUM_INPUTS-1:0] w_dir_gnt;
   logic                  w_dir_vld;
   logic [NUM_INPUTS-1:0] w_gnt;
   logic [SEL_WIDTH-1:0]  w_gnt_idx;
   logic                  w_gnt_vld;
   logic                  w_xfer;
   logic [DATA_WIDTH-1:0] w_mux_data;

   assign w_can_accept = !r_vld_p1 || out_ready;

   rr_arbiter #(
      .NUM_INPUTS (NUM_INPUTS)
   ) u_rr (
      .i_req        (in_valid),
      .i_last_grant (r_last_grant),
      .o_gnt        (w_rr_gnt),
      .o_gnt_idx    (w_rr_idx),
      .o_gnt_vld    (w_rr_vld)
   );

   // An out-of-range sel matches no channel, so it simply produces no grant.
   always_comb begin
      w_dir_gnt = '0;
      w_dir_vld = 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (sel == SEL_WIDTH'(i) && in_valid[i]) begin
            w_dir_gnt[i] = 1'b1;
            w_dir_vld    = 1'b1;
         end
      end
   end

   always_comb begin
      if (mode == MODE_RR) begin
         w_gnt     = w_rr_gnt;
         w_gnt_idx = w_rr_idx;
         w_gnt_vld = w_rr_vld;
      end else begin
         w_gnt     = w_dir_gnt;
         w_gnt_idx = sel;
         w_gnt_vld = w_dir_vld;
      end
   end

   always_comb begin
      w_mux_data = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (w_gnt_idx == SEL_WIDTH'(i)) w_mux_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Reset blocks every handshake so nothing is consumed during a reset cycle.
   assign in_ready = (w_can_accept && !rst) ? w_gnt : '0;
   assign w_xfer   = w_gnt_vld && w_can_accept && !rst;

   // Stage p1: output register and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p1     <= 1'b0;
         r_data_p1    <= '0;
         r_src_p1     <= '0;
         r_last_grant <= SEL_WIDTH'(NUM_INPUTS - 1);
      end else if (w_xfer) begin
         r_vld_p1  <= 1'b1;
         r_data_p1 <= w_mux_data;
         r_src_p1  <= w_gnt_idx;
         if (mode == MODE_RR) r_last_grant <= w_gnt_idx;
      end else if (out_ready) begin
         r_vld_p1 <= 1'b0;
      end
   end

   assign out_data  = r_data_p1;
   assign out_valid = r_vld_p1;
   assign out_src   = r_src_p1;

endmodule

// File: doc/arb_mux_nx1.md
Name: arb_mux_nx1

Overview:
- Parametrised, registered N-to-1 data multiplexer with valid/ready handshakes on every input and on the output.
- Two modes: direct select (the path a plain 2x1 mux uses) and round-robin arbitration among valid inputs.
- One output register stage. It is used where several MIPS datapath or bus sources share one sink that can stall.

Parameters:
- DATA_WIDTH, 32, width of each data word.
- NUM_INPUTS, 4, number of input channels (legal range 2..16).
- SEL_WIDTH, derived as clog2(NUM_INPUTS) (1 when NUM_INPUTS=2), width of sel and out_src; local, not overridable.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = direct select, 1 = round-robin.
- sel  input  SEL_WIDTH  channel index used in direct mode.
- in_data  input  NUM_INPUTS*DATA_WIDTH  flattened inputs; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  NUM_INPUTS  per-channel valid.
- in_ready  output  NUM_INPUTS  per-channel ready (one-hot or zero).
- out_data  output  DATA_WIDTH  registered selected word.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  sink accepts the word.
- out_src  output  SEL_WIDTH  index of the channel out_data came from.

Behaviour:
- Reset: on rising edge with rst=1, these values apply:
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer last_grant=NUM_INPUTS-1, so input 0 has first priority.
  - in_ready=0 for the whole cycle in which rst=1.
- Reset mid-transfer: a held word is discarded. No handshake completes in a reset cycle.
- can_accept = !out_valid | out_ready. The output register is empty or is draining this cycle.
- Grant, direct mode (mode=0):
  - grant = sel when sel < NUM_INPUTS and in_valid[sel]=1; otherwise no grant.
  - Valid inputs on other channels are ignored (stay stalled).
- Grant, round-robin mode (mode=1):
  - Search channels last_grant+1, last_grant+2, ... with wrap modulo NUM_INPUTS.
  - The first channel with in_valid=1 wins; no valid input means no grant.
- in_ready[grant]=can_accept. All other in_ready bits are 0. in_ready is combinational from in_valid/mode/sel/state; in_ready never depends on in_data.
- Transfer on input: in_valid[g] & in_ready[g]. Next edge: out_data <= channel g word, out_src <= g, out_valid <= 1. Latency is exactly 1 cycle from input handshake to out_valid.
- Output drain: out_valid & out_ready with no new input transfer gives out_valid <= 0 next edge.
- Simultaneous drain and input transfer in one cycle: the register reloads and out_valid stays 1. Full throughput is one word per cycle.
- Stall: out_valid=1 and out_ready=0 means out_data and out_src are held bit-stable and every in_ready is 0.
- last_grant updates to g only on an input transfer in round-robin mode. Direct-mode transfers do not move the pointer.
- mode and sel are sampled combinationally each cycle. A change affects the next arbitration only; a held word is never altered.
- sel out of range (NUM_INPUTS not a power of 2): no grant and no X propagation.
- The block holds no data-dependent state beyond the single register. There is no overflow case.

Decomposition:
- Shared package (mips_pkg): constants MODE_DIRECT=1'b0 and MODE_RR=1'b1; a clog2 function used for SEL_WIDTH.
- One sub-module: rr_arbiter (NUM_INPUTS param). Inputs: req vector and last_grant. Outputs: one-hot gnt and encoded index. Purely combinational; the pointer register lives in arb_mux_nx1.

Test Plan:
- Reset mid-stall: load a word, hold out_ready=0, assert rst for 1 cycle. Required: out_valid=0, out_data=0, out_src=0, in_ready=0 during reset, and the word is never emitted.
- Direct mode, 4 inputs, sel=2, in_valid=4'b1111, data 0x11111111/0x22222222/0x33333333/0x44444444, out_ready=1. Required: in_ready=4'b0100, next cycle out_data=0x33333333 and out_src=2.
- Round-robin, all four valid for 8 cycles, out_ready=1, after reset. Required: out_src sequence 0,1,2,3,0,1,2,3, and out_valid=1 every cycle from the 2nd cycle on.
- Round-robin, in_valid=4'b1010, out_ready=1. Required: out_src alternates 1,3,1,3; channels 0 and 2 never receive in_ready.
- Back-pressure: out_ready=0 for 3 cycles after a load of 0xDEADBEEF. Required: out_data stays 0xDEADBEEF, all in_ready=0, and no channel is lost once out_ready returns to 1.
- Direct mode, sel=1, in_valid[1]=0, in_valid[0]=1. Required: no grant and out_valid stays 0. Then switch mode=1; the next cycle grants channel 0.
